// File: rtl/sdc_user_responder.sv
// rtl/sdc_user_responder.sv - SDRAM-controller user-port responder backed by an internal word memory
//
// Answers burst requests on the controller user port from a 2**AW x 32 memory so
// initiators can be brought up without the SDRAM core or a device model.
//
// Ports:
//   i_sdc_clk        clock, rising edge
//   i_s_reset        synchronous reset, active-high (memory contents are kept)
//   i_sdc_en         1 = requests may be accepted, 0 = accepting stalled
//   i_sdc_req        request valid, held until o_sdc_req_ack
//   i_sdc_req_adr    word address; only [AW-1:0] used
//   i_sdc_req_len    burst length code, N = 4 << len words
//   i_sdc_req_wr_n   0 = write, 1 = read
//   i_sdc_wr_data    write word, sampled on edges where o_sdc_wr_next = 1
//   i_sdc_wr_en_n    active-low byte mask
//   o_sdc_req_ack    one-cycle accept pulse
//   o_sdc_wr_next    write-word pull strobe
//   o_sdc_rd_data    read word, 0 when o_sdc_rd_valid = 0
//   o_sdc_rd_valid   read-data qualifier
//   o_sdc_init_done  responder ready
module sdc_user_responder #(
  parameter int AW       = 9,
  parameter int INIT_CYC = 16,
  parameter int RD_LAT   = 3
) (
  input  logic        i_sdc_clk,
  input  logic        i_s_reset,
  input  logic        i_sdc_en,
  input  logic        i_sdc_req,
  input  logic [22:0] i_sdc_req_adr,
  input  logic [1:0]  i_sdc_req_len,
  input  logic        i_sdc_req_wr_n,
  input  logic [31:0] i_sdc_wr_data,
  input  logic [3:0]  i_sdc_wr_en_n,
  output logic        o_sdc_req_ack,
  output logic        o_sdc_wr_next,
  output logic [31:0] o_sdc_rd_data,
  output logic        o_sdc_rd_valid,
  output logic        o_sdc_init_done
);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_ACK   = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;
  localparam logic [2:0] S_RD    = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

  localparam int CW = 16;
  localparam logic [CW-1:0] C_INIT_LAST  = CW'(INIT_CYC - 1);
  localparam logic [CW-1:0] C_RWAIT_LAST = CW'(RD_LAT - 1);

  logic [2:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_ptr;
  logic [1:0]    r_len;
  logic          r_wr_n;
  logic [3:0]    r_mask;
  logic          r_init_done;
  logic          r_rd_valid;
  logic [31:0]   r_rd_data;
  logic [31:0]   r_mem [2**AW];

  logic [5:0]    w_n_m1;
  logic          w_last;
  logic          w_unused;

  // Upper address bits (bank/row beyond the memory depth) are ignored.
  assign w_unused = ^i_sdc_req_adr[22:AW];

  assign w_n_m1 = (6'd4 << r_len) - 6'd1;
  assign w_last = (r_cnt == {{(CW-6){1'b0}}, w_n_m1});

  assign o_sdc_req_ack   = (r_state == S_ACK);
  assign o_sdc_wr_next   = (r_state == S_WR);
  assign o_sdc_rd_valid  = r_rd_valid;
  assign o_sdc_rd_data   = r_rd_data;
  assign o_sdc_init_done = r_init_done;

  // Memory has no reset so contents survive a reset, even one that lands mid-burst.
  always_ff @(posedge i_sdc_clk) begin
    if (!i_s_reset && r_state == S_WR) begin
      for (int b = 0; b < 4; b++) begin
        if (!r_mask[b]) begin
          r_mem[r_ptr][8*b +: 8] <= i_sdc_wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_sdc_clk) begin
    if (i_s_reset) begin
      r_state     <= S_INIT;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_len       <= '0;
      r_wr_n      <= 1'b0;
      r_mask      <= '0;
      r_init_done <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_cnt == C_INIT_LAST) begin
            r_init_done <= 1'b1;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_IDLE: begin
          if (i_sdc_req && i_sdc_en && r_init_done) begin
            r_ptr   <= i_sdc_req_adr[AW-1:0];
            r_len   <= i_sdc_req_len;
            r_wr_n  <= i_sdc_req_wr_n;
            r_mask  <= i_sdc_wr_en_n;
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_cnt   <= '0;
          r_state <= r_wr_n ? S_RWAIT : S_WR;
        end
        S_WR: begin
          r_ptr <= r_ptr + AW'(1);
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RWAIT: begin
          // The first word is fetched on the last wait edge so valid and data rise together.
          if (r_cnt == C_RWAIT_LAST) begin
            r_cnt      <= '0;
            r_rd_valid <= 1'b1;
            r_rd_data  <= r_mem[r_ptr];
            r_ptr      <= r_ptr + AW'(1);
            r_state    <= S_RD;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RD: begin
          // r_cnt is the index of the word currently on o_sdc_rd_data.
          if (w_last) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_cnt      <= '0;
            r_state    <= S_GAP;
          end else begin
            r_rd_data <= r_mem[r_ptr];
            r_ptr     <= r_ptr + AW'(1);
            r_cnt     <= r_cnt + CW'(1);
          end
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sdc_user_responder.sv
// tb/tb_sdc_user_responder.sv - directed self-checking bench for sdc_user_responder
module tb_sdc_user_responder;

  localparam int AW       = 9;
  localparam int INIT_CYC = 16;
  localparam int RD_LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        req;
  logic [22:0] adr;
  logic [1:0]  len;
  logic        wr_n;
  logic [31:0] wr_data;
  logic [3:0]  mask;
  logic        ack;
  logic        wr_next;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        init_done;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] wdata [32];
  logic [31:0] rdata [32];

  sdc_user_responder #(.AW(AW), .INIT_CYC(INIT_CYC), .RD_LAT(RD_LAT)) dut (
    .i_sdc_clk       (clk),
    .i_s_reset       (rst),
    .i_sdc_en        (en),
    .i_sdc_req       (req),
    .i_sdc_req_adr   (adr),
    .i_sdc_req_len   (len),
    .i_sdc_req_wr_n  (wr_n),
    .i_sdc_wr_data   (wr_data),
    .i_sdc_wr_en_n   (mask),
    .o_sdc_req_ack   (ack),
    .o_sdc_wr_next   (wr_next),
    .o_sdc_rd_data   (rd_data),
    .o_sdc_rd_valid  (rd_valid),
    .o_sdc_init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic wn, input logic [1:0] l, input logic [22:0] a,
                           input logic [3:0] m, output bit ok);
    wr_n = wn; len = l; adr = a; mask = m; req = 1'b1; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ack) begin
        ok = 1'b1;
        break;
      end
    end
    req = 1'b0;
  endtask

  task automatic run_write(output int n);
    n = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (wr_next) begin
        wr_data = wdata[n & 31];
        n++;
      end else if (n > 0) begin
        break;
      end
    end
  endtask

  task automatic run_read(output int lat, output int n);
    lat = 0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (rd_valid) begin
        rdata[n & 31] = rd_data;
        n++;
      end else if (n > 0) begin
        break;
      end else begin
        lat++;
      end
    end
  endtask

  task automatic test_reset();
    int  cyc;
    bit  early;
    rst = 1'b1; en = 1'b1; req = 1'b1; wr_n = 1'b1; len = 2'd0; adr = '0; mask = '0; wr_data = '0;
    tick();
    tick();
    n_total++;
    if ({ack, wr_next, rd_valid, init_done, rd_data} !== 36'd0)
      $display("FAIL reset_outputs: got %h expected 0", {ack, wr_next, rd_valid, init_done, rd_data});
    else n_pass++;
    rst = 1'b0;
    cyc = 0;
    early = 1'b0;
    while (!init_done && cyc < 100) begin
      tick();
      cyc++;
      if (ack && !init_done) early = 1'b1;
    end
    n_total++;
    if (cyc !== INIT_CYC) $display("FAIL init_cycles: got %0d expected %0d", cyc, INIT_CYC);
    else n_pass++;
    n_total++;
    if (early !== 1'b0) $display("FAIL ack_before_init: got %0d expected 0", early);
    else n_pass++;
    tick();
    n_total++;
    if (ack !== 1'b1) $display("FAIL t1_ack_rise: got %b expected 1", ack);
    else n_pass++;
    req = 1'b0;
    tick();
    n_total++;
    if (ack !== 1'b0) $display("FAIL t1_ack_pulse: got %b expected 0", ack);
    else n_pass++;
    repeat (12) tick();
  endtask

  task automatic test_write_read();
    bit ok;
    int n, lat;
    for (int k = 0; k < 32; k++) wdata[k] = k;
    start_req(1'b0, 2'd0, 23'h000200, 4'h0, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL t2_wr_ack: got %b expected 1", ok); else n_pass++;
    run_write(n);
    n_total++;
    if (n !== 4) $display("FAIL t2_wr_next_count: got %0d expected 4", n); else n_pass++;
    start_req(1'b1, 2'd0, 23'h000200, 4'h0, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL t2_rd_ack: got %b expected 1", ok); else n_pass++;
    run_read(lat, n);
    n_total++;
    if (lat !== RD_LAT) $display("FAIL t2_rd_latency: got %0d expected %0d", lat, RD_LAT); else n_pass++;
    n_total++;
    if (n !== 4) $display("FAIL t2_rd_count: got %0d expected 4", n); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (rdata[k] !== 32'(k)) $display("FAIL t2_rd_data[%0d]: got %h expected %h", k, rdata[k], 32'(k));
      else n_pass++;
    end
    n_total++;
    if (rd_data !== 32'd0) $display("FAIL t2_rd_data_idle: got %h expected 0", rd_data); else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    int n, lat;
    for (int k = 0; k < 32; k++) wdata[k] = k;
    start_req(1'b0, 2'd3, 23'h0001FF, 4'h0, ok);
    run_write(n);
    n_total++;
    if (n !== 32) $display("FAIL t3_wr_next_count: got %0d expected 32", n); else n_pass++;
    start_req(1'b1, 2'd3, 23'h0001FF, 4'h0, ok);
    run_read(lat, n);
    n_total++;
    if (n !== 32) $display("FAIL t3_rd_count: got %0d expected 32", n); else n_pass++;
    for (int k = 0; k < 32; k++) begin
      n_total++;
      if (rdata[k] !== 32'(k)) $display("FAIL t3_rd_data[%0d]: got %h expected %h", k, rdata[k], 32'(k));
      else n_pass++;
    end
    start_req(1'b1, 2'd0, 23'h000000, 4'h0, ok);
    run_read(lat, n);
    n_total++;
    if (rdata[0] !== 32'd1) $display("FAIL t3_wrap_mem0: got %h expected 00000001", rdata[0]); else n_pass++;
  endtask

  task automatic test_mask();
    bit ok;
    int n, lat;
    for (int k = 0; k < 32; k++) wdata[k] = 32'hFFFF_FFFF;
    start_req(1'b0, 2'd0, 23'h000040, 4'h0, ok);
    run_write(n);
    for (int k = 0; k < 32; k++) wdata[k] = 32'h1234_5678;
    start_req(1'b0, 2'd0, 23'h000040, 4'b1010, ok);
    run_write(n);
    start_req(1'b1, 2'd0, 23'h000040, 4'h0, ok);
    run_read(lat, n);
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (rdata[k] !== 32'hFF34_FF78) $display("FAIL t4_mask_a[%0d]: got %h expected ff34ff78", k, rdata[k]);
      else n_pass++;
    end
    for (int k = 0; k < 32; k++) wdata[k] = 32'hAAAA_AAAA;
    start_req(1'b0, 2'd0, 23'h000040, 4'hF, ok);
    run_write(n);
    n_total++;
    if (n !== 4) $display("FAIL t4_maskf_wr_next: got %0d expected 4", n); else n_pass++;
    start_req(1'b1, 2'd0, 23'h000040, 4'h0, ok);
    run_read(lat, n);
    n_total++;
    if (rdata[2] !== 32'hFF34_FF78) $display("FAIL t4_mask_f: got %h expected ff34ff78", rdata[2]); else n_pass++;
  endtask

  task automatic test_enable_stall();
    bit ok;
    int n, lat, acks;
    for (int k = 0; k < 32; k++) wdata[k] = 32'h5000 + k;
    en = 1'b0; wr_n = 1'b0; len = 2'd1; adr = 23'h000080; mask = 4'h0; req = 1'b1;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack) acks++;
    end
    n_total++;
    if (acks !== 0) $display("FAIL t5_stall_ack: got %0d expected 0", acks); else n_pass++;
    en = 1'b1;
    tick();
    n_total++;
    if (ack !== 1'b1) $display("FAIL t5_ack_after_en: got %b expected 1", ack); else n_pass++;
    req = 1'b0; wr_n = 1'b1; len = 2'd3; mask = 4'hF; adr = 23'h000000;
    run_write(n);
    n_total++;
    if (n !== 8) $display("FAIL t5_captured_len: got %0d expected 8", n); else n_pass++;
    start_req(1'b1, 2'd1, 23'h000080, 4'h0, ok);
    run_read(lat, n);
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if (rdata[k] !== 32'h5000 + k) $display("FAIL t5_rd_data[%0d]: got %h expected %h", k, rdata[k], 32'h5000 + k);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    int n, lat, cyc;
    for (int k = 0; k < 32; k++) wdata[k] = 32'hA0 + k;
    start_req(1'b0, 2'd2, 23'h000100, 4'h0, ok);
    run_write(n);
    start_req(1'b1, 2'd2, 23'h000100, 4'h0, ok);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rd_valid) begin
        if (n == 5) break;
        n++;
      end
    end
    n_total++;
    if (rd_data !== 32'hA5) $display("FAIL t6_word5: got %h expected 000000a5", rd_data); else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if ({rd_valid, ack, wr_next, init_done} !== 4'b0000)
      $display("FAIL t6_reset_outputs: got %b expected 0000", {rd_valid, ack, wr_next, init_done});
    else n_pass++;
    cyc = 0;
    while (!init_done && cyc < 100) begin
      tick();
      cyc++;
    end
    n_total++;
    if (cyc !== INIT_CYC) $display("FAIL t6_reinit_cycles: got %0d expected %0d", cyc, INIT_CYC); else n_pass++;
    start_req(1'b1, 2'd2, 23'h000100, 4'h0, ok);
    run_read(lat, n);
    n_total++;
    if (n !== 16) $display("FAIL t6_rd_count: got %0d expected 16", n); else n_pass++;
    for (int k = 0; k < 16; k++) begin
      n_total++;
      if (rdata[k] !== 32'hA0 + k) $display("FAIL t6_rd_data[%0d]: got %h expected %h", k, rdata[k], 32'hA0 + k);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_mask();
    test_enable_stall();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
